// File: rtl/fifo_rr_arbiter.sv
// Round-robin read arbiter: drains CH_AMOUNT show-ahead FIFOs into one
// valid/ready stream, up to MAX_BURST words per grant, then rotates priority.
//
// state | meaning
// IDLE  | arbitrate: pick first non-empty channel after last_grant (1 cycle)
// BURST | pop granted channel into the output register whenever load_en
module fifo_rr_arbiter #(
   parameter int CH_AMOUNT  = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4,
   parameter int CH_WIDTH   = $clog2(CH_AMOUNT)
) (
   input  logic                            clk_i,
   input  logic                            rst_n_i,
   input  logic [CH_AMOUNT-1:0]            fifo_empty_i,
   input  logic [CH_AMOUNT*DATA_WIDTH-1:0] fifo_data_i,
   output logic [CH_AMOUNT-1:0]            fifo_rd_o,
   output logic [DATA_WIDTH-1:0]           data_o,
   output logic [CH_WIDTH-1:0]             ch_o,
   output logic                            valid_o,
   input  logic                            ready_i,
   output logic                            busy_o
);
   localparam int                   CNT_WIDTH = $clog2(MAX_BURST + 1);
   localparam logic [CH_WIDTH-1:0]  LAST_CH   = CH_WIDTH'(CH_AMOUNT - 1);
   localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(MAX_BURST - 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t               state, state_nxt;
   logic [CH_WIDTH-1:0]  grant, last_grant, cand, found_ch;
   logic [CNT_WIDTH-1:0] burst_cnt;
   logic                 found, load_en, pop, last_beat;

   assign load_en   = !valid_o || ready_i;
   assign pop       = (state == BURST) && load_en && !fifo_empty_i[grant];
   assign last_beat = (burst_cnt == LAST_BEAT);
   assign busy_o    = (state == BURST);

   // explicit wrap keeps the rotation correct for non-power-of-2 channel counts
   always_comb begin
      found    = 1'b0;
      found_ch = '0;
      cand     = last_grant;
      for (int i = 0; i < CH_AMOUNT; i++) begin
         cand = (cand == LAST_CH) ? '0 : cand + 1'b1;
         if (!found && !fifo_empty_i[cand]) begin
            found    = 1'b1;
            found_ch = cand;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      fifo_rd_o = '0;
      case (state)
         IDLE: begin
            if (found) state_nxt = BURST;
         end
         BURST: begin
            fifo_rd_o[grant] = pop;
            if (pop && last_beat)     state_nxt = IDLE;
            else if (load_en && !pop) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // a stalled output (valid && !ready) leaves everything untouched
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         grant      <= '0;
         last_grant <= LAST_CH;
         burst_cnt  <= '0;
         valid_o    <= 1'b0;
         data_o     <= '0;
         ch_o       <= '0;
      end else if (state == IDLE) begin
         if (ready_i) valid_o <= 1'b0;
         if (found) begin
            grant      <= found_ch;
            last_grant <= found_ch;
            burst_cnt  <= '0;
         end
      end else if (pop) begin
         data_o    <= fifo_data_i[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
         ch_o      <= grant;
         valid_o   <= 1'b1;
         burst_cnt <= burst_cnt + 1'b1;
      end else if (load_en) begin
         valid_o <= 1'b0;
      end
   end
endmodule
